// File: rtl/alu_result_writeback_if.sv
// Handshake bundle between the ALU output, this write-back stage and the register-file bus.
// The master side produces results and consumes beats; the slave side is the write-back stage.
interface alu_result_writeback_if #(
   parameter int DATA_W = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [2*DATA_W-1:0]   alu_result;
   logic [4:0]            opcode;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_data;
   logic [1:0]            out_dest;

   modport master (
      output in_valid, alu_result, opcode, out_ready,
      input  in_ready, out_valid, out_data, out_dest
   );

   modport slave (
      input  in_valid, alu_result, opcode, out_ready,
      output in_ready, out_valid, out_data, out_dest
   );
endinterface

// File: rtl/alu_result_writeback.sv
// ALU write-back stage: latches a 64-bit result into Z, then emits one Rz beat or two LO/HI beats
// (MUL/DIV) with a valid/ready handshake, updating the HI/LO registers as those beats complete.
module alu_result_writeback #(
   parameter int          DATA_W = 32,
   parameter logic [4:0]  MUL_OP = 5'b01111,
   parameter logic [4:0]  DIV_OP = 5'b10000
) (
   input  logic                   clk,
   input  logic                   clr,
   alu_result_writeback_if.slave  bus,
   output logic [DATA_W-1:0]      hi_q,
   output logic [DATA_W-1:0]      lo_q,
   output logic                   illegal_op
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WB_RZ = 2'd1,
      WB_LO = 2'd2,
      WB_HI = 2'd3
   } state_t;

   localparam logic [1:0] DEST_RZ = 2'b00;
   localparam logic [1:0] DEST_LO = 2'b01;
   localparam logic [1:0] DEST_HI = 2'b10;

   state_t              r_state;
   state_t              w_next;
   logic [2*DATA_W-1:0] r_z;
   logic [4:0]          r_op;
   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;
   logic [DATA_W-1:0]   r_last;
   logic                r_illegal;

   logic                w_accept;
   logic                w_beat_done;
   logic                w_is_wide;
   logic                w_is_single;
   logic                w_wide_q;
   logic [DATA_W-1:0]   w_out_data;
   logic [1:0]          w_out_dest;

   // in_ready is gated by clr so the stage never advertises space while held in reset.
   assign bus.in_ready = clr & (r_state == IDLE);
   assign w_accept     = bus.in_valid & bus.in_ready;
   assign bus.out_valid = (r_state != IDLE);
   assign w_beat_done  = bus.out_valid & bus.out_ready;

   assign w_is_wide   = (bus.opcode == MUL_OP) || (bus.opcode == DIV_OP);
   assign w_is_single = ((bus.opcode >= 5'b00011) && (bus.opcode <= 5'b01110)) ||
                        (bus.opcode == 5'b10001) || (bus.opcode == 5'b10010);
   assign w_wide_q    = (r_op == MUL_OP) || (r_op == DIV_OP);

   // Beat payload comes only from registers; IDLE replays the last completed beat.
   always_comb begin
      w_out_data = r_last;
      w_out_dest = DEST_RZ;
      case (r_state)
         WB_RZ: begin
            w_out_data = r_z[DATA_W-1:0];
            w_out_dest = DEST_RZ;
         end
         WB_LO: begin
            w_out_data = r_z[DATA_W-1:0];
            w_out_dest = DEST_LO;
         end
         WB_HI: begin
            w_out_data = r_z[2*DATA_W-1:DATA_W];
            w_out_dest = DEST_HI;
         end
         default: begin
            w_out_data = r_last;
            w_out_dest = DEST_RZ;
         end
      endcase
   end

   assign bus.out_data = w_out_data;
   assign bus.out_dest = w_out_dest;
   assign hi_q         = r_hi;
   assign lo_q         = r_lo;
   assign illegal_op   = r_illegal;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_is_wide)        w_next = WB_LO;
               else if (w_is_single) w_next = WB_RZ;
               else                  w_next = IDLE;
            end
         end
         WB_RZ: if (w_beat_done) w_next = IDLE;
         WB_LO: if (w_beat_done) w_next = w_wide_q ? WB_HI : IDLE;
         WB_HI: if (w_beat_done) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state   <= IDLE;
         r_z       <= '0;
         r_op      <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_last    <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_illegal <= w_accept & ~w_is_wide & ~w_is_single;
         // Z and op are captured even for dropped opcodes.
         if (w_accept) begin
            r_z  <= bus.alu_result;
            r_op <= bus.opcode;
         end
         if (w_beat_done) begin
            r_last <= w_out_data;
            if (r_state == WB_LO) r_lo <= w_out_data;
            if (r_state == WB_HI) r_hi <= w_out_data;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Bench for alu_result_writeback: directed spec scenarios then random traffic, checked against
// a queue-of-pending-beats model.
module tb_alu_result_writeback;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          clr;
   logic [DW-1:0] hi_q, lo_q;
   logic          illegal_op;

   alu_result_writeback_if #(.DATA_W(DW)) bus();

   alu_result_writeback #(.DATA_W(DW)) dut (
      .clk        (clk),
      .clr        (clr),
      .bus        (bus),
      .hi_q       (hi_q),
      .lo_q       (lo_q),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [1:0]    dst;
   } beat_t;

   beat_t         m_q[$];
   logic [DW-1:0] m_hi, m_lo, m_last;
   logic          m_ill;
   int            n_chk = 0;
   int            n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph, input bit in_rst);
      logic [DW-1:0] ed;
      logic [1:0]    edst;
      ed   = m_last;
      edst = 2'b00;
      if (m_q.size() != 0) begin
         ed   = m_q[0].d;
         edst = m_q[0].dst;
      end
      chk({ph, " in_ready"},   64'(bus.in_ready),  64'(!in_rst && m_q.size() == 0));
      chk({ph, " out_valid"},  64'(bus.out_valid), 64'(m_q.size() != 0));
      chk({ph, " out_data"},   64'(bus.out_data),  64'(ed));
      chk({ph, " out_dest"},   64'(bus.out_dest),  64'(edst));
      chk({ph, " hi_q"},       64'(hi_q),          64'(m_hi));
      chk({ph, " lo_q"},       64'(lo_q),          64'(m_lo));
      chk({ph, " illegal_op"}, 64'(illegal_op),    64'(m_ill));
   endtask

   task automatic model_reset();
      m_q.delete();
      m_hi = '0; m_lo = '0; m_last = '0; m_ill = 1'b0;
   endtask

   task automatic drv(input logic v, input logic [4:0] op, input logic [63:0] r, input logic rdy);
      bus.in_valid   = v;
      bus.opcode     = op;
      bus.alu_result = r;
      bus.out_ready  = rdy;
   endtask

   // One clock: decide the handshakes from pre-edge inputs, advance the model, compare after the edge.
   task automatic cyc(input string ph);
      logic        acc, done;
      logic [4:0]  op;
      logic [63:0] res;
      beat_t       b;
      acc  = bus.in_valid && (m_q.size() == 0);
      done = (m_q.size() != 0) && bus.out_ready;
      op   = bus.opcode;
      res  = bus.alu_result;
      @(posedge clk);
      #1;
      m_ill = 1'b0;
      if (done) begin
         b = m_q.pop_front();
         m_last = b.d;
         if (b.dst == 2'b01) m_lo = b.d;
         if (b.dst == 2'b10) m_hi = b.d;
      end
      if (acc) begin
         if (op == 5'd15 || op == 5'd16) begin
            m_q.push_back('{d: res[31:0],  dst: 2'b01});
            m_q.push_back('{d: res[63:32], dst: 2'b10});
         end else if ((op >= 5'd3 && op <= 5'd14) || op == 5'd17 || op == 5'd18) begin
            m_q.push_back('{d: res[31:0], dst: 2'b00});
         end else begin
            m_ill = 1'b1;
         end
      end
      check_all(ph, 1'b0);
   endtask

   initial begin
      clr = 1'b0;
      drv(1'b0, 5'd0, 64'd0, 1'b0);
      model_reset();
      #2;
      check_all("reset", 1'b1);
      @(negedge clk); clr = 1'b1; #1;
      check_all("post_reset", 1'b0);

      // ADD: single Rz beat
      drv(1'b1, 5'b00011, 64'h0000_0000_0000_0007, 1'b1); cyc("add_acc");
      drv(1'b0, 5'd0, 64'd0, 1'b1);                       cyc("add_beat");
      cyc("add_idle");

      // MUL: LO then HI
      drv(1'b1, 5'b01111, 64'h0000_0001_FFFF_FFFE, 1'b1); cyc("mul_acc");
      drv(1'b0, 5'd0, 64'd0, 1'b1);                       cyc("mul_lo");
      cyc("mul_hi");
      cyc("mul_idle");

      // DIV with backpressure and ignored in_valid pulses
      drv(1'b1, 5'b10000, {32'd3, 32'd14}, 1'b0); cyc("div_acc");
      for (int i = 0; i < 3; i++) begin
         drv(i % 2 == 0, 5'b00011, 64'hDEAD_BEEF_0000_0001, 1'b0);
         cyc("div_hold");
      end
      drv(1'b0, 5'd0, 64'd0, 1'b1); cyc("div_lo");
      cyc("div_hi");
      cyc("div_idle");

      // Illegal opcode
      drv(1'b1, 5'b11111, 64'h0000_0055_0000_0055, 1'b1); cyc("ill_acc");
      drv(1'b0, 5'd0, 64'd0, 1'b1);                       cyc("ill_after");

      // Back-to-back NOT then SUB with in_valid held
      drv(1'b1, 5'b10010, 64'h11, 1'b1); cyc("b2b_not");
      drv(1'b1, 5'b00100, 64'h22, 1'b1); cyc("b2b_beat1");
      cyc("b2b_sub");
      drv(1'b0, 5'd0, 64'd0, 1'b1);      cyc("b2b_beat2");
      cyc("b2b_idle");

      // Reset while a MUL sits in WB_HI
      drv(1'b1, 5'b01111, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1); cyc("rst_acc");
      drv(1'b0, 5'd0, 64'd0, 1'b1); cyc("rst_lo");
      drv(1'b0, 5'd0, 64'd0, 1'b0); cyc("rst_hold_hi");
      @(negedge clk); clr = 1'b0; #1;
      model_reset();
      check_all("mid_reset", 1'b1);
      #2; clr = 1'b1; #1;
      check_all("mid_release", 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [4:0] op;
         if ($urandom_range(0, 3) == 0) op = $urandom_range(0, 1) ? 5'd15 : 5'd16;
         else                           op = 5'($urandom_range(0, 31));
         drv(1'($urandom_range(0, 1)), op, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
         cyc("rand");
      end

      drv(1'b0, 5'd0, 64'd0, 1'b1);
      for (int i = 0; i < 4; i++) cyc("drain");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
